// File: rtl/memory_access_stage_if.sv
// EX-to-MEM inputs, hazard controls and MEM/WB outputs of the MEM stage.
// master drives the EX side; slave is the MEM stage itself.
interface memory_access_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] add_result;
  logic [31:0] alu_result;
  logic [31:0] read_data2_in;
  logic [4:0]  write_reg_in;
  logic        zero_in;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  write_reg_out;
  logic        MemtoReg_out;
  logic        RegWrite_out;
  logic        mem_fault;

  modport master (
    output stall, flush, add_result, alu_result, read_data2_in, write_reg_in, zero_in,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch,
    input  pc_src, branch_target, read_data_out, alu_result_out, write_reg_out,
           MemtoReg_out, RegWrite_out, mem_fault
  );

  modport slave (
    input  stall, flush, add_result, alu_result, read_data2_in, write_reg_in, zero_in,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch,
    output pc_src, branch_target, read_data_out, alu_result_out, write_reg_out,
           MemtoReg_out, RegWrite_out, mem_fault
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: EX/MEM and MEM/WB registers, word-addressed data memory, branch resolve.
// Latency 2 edges EX->WB; stall freezes both registers and memory writes, flush bubbles EX/MEM control.
module memory_access_stage #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  memory_access_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] add_result;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [4:0]  write_reg;
    logic        zero;
  } exmem_dat_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } exmem_ctl_t;

  exmem_dat_t          exmem_dat;
  exmem_ctl_t          exmem_ctl;
  logic [31:0]         mem [MEM_DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic                aligned;
  logic                fault;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         memwb_read_data;
  logic [31:0]         memwb_alu_result;
  logic [4:0]          memwb_write_reg;
  logic                memwb_mem_to_reg;
  logic                memwb_reg_write;
  logic                memwb_fault;

  // flush clears control even while stalled; data only moves when not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_dat <= '0;
      exmem_ctl <= '0;
    end else begin
      if (!bus.stall) begin
        exmem_dat <= '{add_result: bus.add_result, alu_result: bus.alu_result,
                       read_data2: bus.read_data2_in, write_reg: bus.write_reg_in,
                       zero: bus.zero_in};
      end
      if (bus.flush) begin
        exmem_ctl <= '0;
      end else if (!bus.stall) begin
        exmem_ctl <= '{mem_to_reg: bus.MemtoReg, reg_write: bus.RegWrite,
                       mem_read: bus.MemRead, mem_write: bus.MemWrite, branch: bus.Branch};
      end
    end
  end

  always_comb begin
    idx     = exmem_dat.alu_result[ADDR_W+1:2];
    aligned = (exmem_dat.alu_result[1:0] == 2'b00);
    fault   = !aligned && (exmem_ctl.mem_read || exmem_ctl.mem_write);
    wr_en   = exmem_ctl.mem_write && aligned && !bus.stall;
    rd_en   = exmem_ctl.mem_read && aligned;
  end

  // Not reset; a write coinciding with reset assertion is dropped
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[idx] <= exmem_dat.read_data2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_read_data  <= '0;
      memwb_alu_result <= '0;
      memwb_write_reg  <= '0;
      memwb_mem_to_reg <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_fault      <= 1'b0;
    end else if (!bus.stall) begin
      memwb_read_data  <= rd_en ? mem[idx] : 32'h0;
      memwb_alu_result <= exmem_dat.alu_result;
      memwb_write_reg  <= exmem_dat.write_reg;
      memwb_mem_to_reg <= exmem_ctl.mem_to_reg;
      memwb_reg_write  <= exmem_ctl.reg_write && !fault;
      memwb_fault      <= fault;
    end
  end

  assign bus.pc_src         = exmem_ctl.branch && exmem_dat.zero;
  assign bus.branch_target  = exmem_dat.add_result;
  assign bus.read_data_out  = memwb_read_data;
  assign bus.alu_result_out = memwb_alu_result;
  assign bus.write_reg_out  = memwb_write_reg;
  assign bus.MemtoReg_out   = memwb_mem_to_reg;
  assign bus.RegWrite_out   = memwb_reg_write;
  assign bus.mem_fault      = memwb_fault;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed vectors for the MEM stage: reset, store/load, wrap, branch, misalignment, stall/flush.
module tb_memory_access_stage;
  // control encoding {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LW   = 5'b11100;
  localparam logic [4:0] C_SW   = 5'b00010;
  localparam logic [4:0] C_ALU  = 5'b01000;
  localparam logic [4:0] C_BR   = 5'b00001;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  memory_access_stage_if bus ();

  memory_access_stage #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [31:0] alu, input logic [31:0] wdat, input logic [31:0] tgt,
                    input logic [4:0] wr, input logic [4:0] ctl, input logic z);
    bus.alu_result    = alu;
    bus.read_data2_in = wdat;
    bus.add_result    = tgt;
    bus.write_reg_in  = wr;
    bus.zero_in       = z;
    {bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch} = ctl;
  endtask

  task automatic idle();
    ex(32'h0, 32'h0, 32'h0, 5'd0, C_NONE, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    idle();
    rst_n = 1'b1;

    // reset asserted asynchronously between edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc_src",   bus.pc_src, 0);
    chk("rst_target",   bus.branch_target, 0);
    chk("rst_rdata",    bus.read_data_out, 0);
    chk("rst_alu",      bus.alu_result_out, 0);
    chk("rst_ctl", {bus.write_reg_out, bus.MemtoReg_out, bus.RegWrite_out, bus.mem_fault}, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // store then back-to-back load of the same word
    ex(32'h10, 32'hDEADBEEF, 32'h0, 5'd0, C_SW, 1'b0);
    tick();
    ex(32'h10, 32'h0, 32'h0, 5'd5, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("lw_rdata",    bus.read_data_out, 32'hDEADBEEF);
    chk("lw_memtoreg", bus.MemtoReg_out, 1);
    chk("lw_regwrite", bus.RegWrite_out, 1);
    chk("lw_wreg",     bus.write_reg_out, 5);
    chk("lw_alu",      bus.alu_result_out, 32'h10);
    chk("lw_fault",    bus.mem_fault, 0);

    // address wraps modulo 4*MEM_DEPTH
    ex(32'h410, 32'h0, 32'h0, 5'd6, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("wrap_rdata", bus.read_data_out, 32'hDEADBEEF);

    // branch taken / not taken
    ex(32'h0, 32'h0, 32'h40, 5'd0, C_BR, 1'b1);
    tick();
    chk("br_taken",  bus.pc_src, 1);
    chk("br_target", bus.branch_target, 32'h40);
    ex(32'h0, 32'h0, 32'h80, 5'd0, C_BR, 1'b0);
    tick();
    chk("br_not_taken", bus.pc_src, 0);
    chk("br_target2",   bus.branch_target, 32'h80);
    idle();
    tick();

    // misaligned store, RegWrite set to observe the forced clear
    ex(32'h13, 32'h12345678, 32'h0, 5'd4, C_SW | C_ALU, 1'b0);
    tick();
    idle();
    tick();
    chk("sw_mis_fault", bus.mem_fault, 1);
    chk("sw_mis_rw",    bus.RegWrite_out, 0);
    ex(32'h12, 32'h0, 32'h0, 5'd8, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("lw_mis_rdata", bus.read_data_out, 0);
    chk("lw_mis_fault", bus.mem_fault, 1);
    chk("lw_mis_rw",    bus.RegWrite_out, 0);
    chk("lw_mis_alu",   bus.alu_result_out, 32'h12);
    ex(32'h10, 32'h0, 32'h0, 5'd5, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("mis_no_write", bus.read_data_out, 32'hDEADBEEF);
    chk("aligned_fault", bus.mem_fault, 0);

    // store held in EX/MEM by a 3-cycle stall
    ex(32'h55, 32'h0, 32'h0, 5'd7, C_ALU, 1'b0);
    tick();
    ex(32'h20, 32'hCAFEF00D, 32'h0, 5'd0, C_SW, 1'b0);
    tick();
    bus.stall = 1'b1;
    ex(32'h20, 32'h0, 32'h0, 5'd9, C_LW, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu",  bus.alu_result_out, 32'h55);
      chk("stall_wreg", bus.write_reg_out, 7);
      chk("stall_rw",   bus.RegWrite_out, 1);
    end
    bus.stall = 1'b0;
    tick();
    chk("rel_alu", bus.alu_result_out, 32'h20);
    chk("rel_rw",  bus.RegWrite_out, 0);
    idle();
    tick();
    chk("rel_rdata", bus.read_data_out, 32'hCAFEF00D);
    chk("rel_wreg",  bus.write_reg_out, 9);

    // flush turns an ALU op into a bubble but keeps its data
    ex(32'h77, 32'h0, 32'h0, 5'd3, C_ALU, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    tick();
    chk("flush_rw",  bus.RegWrite_out, 0);
    chk("flush_alu", bus.alu_result_out, 32'h77);

    // stall then stall+flush on a store carrying a taken branch
    ex(32'h30, 32'h11111111, 32'h0, 5'd0, C_SW, 1'b0);
    tick();
    idle();
    tick();
    tick();
    ex(32'h30, 32'h22222222, 32'h99, 5'd0, C_SW | C_BR, 1'b1);
    tick();
    chk("sf_pc_src_pre", bus.pc_src, 1);
    bus.stall = 1'b1;
    ex(32'hAAA, 32'h0, 32'h0, 5'd0, C_NONE, 1'b0);
    tick();
    chk("sf_stall_pc", bus.pc_src, 1);
    bus.flush = 1'b1;
    tick();
    chk("sf_pc_src",  bus.pc_src, 0);
    chk("sf_target",  bus.branch_target, 32'h99);
    chk("sf_wb_hold", bus.alu_result_out, 0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    idle();
    tick();
    chk("sf_bubble_alu", bus.alu_result_out, 32'h30);
    chk("sf_bubble_ctl", {bus.MemtoReg_out, bus.RegWrite_out, bus.mem_fault}, 0);
    ex(32'h30, 32'h0, 32'h0, 5'd2, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("sf_no_write", bus.read_data_out, 32'h11111111);

    // reset mid-operation with a branch in EX/MEM; memory survives
    ex(32'h0, 32'h0, 32'h44, 5'd0, C_BR, 1'b1);
    tick();
    chk("mid_pc_pre", bus.pc_src, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc",    bus.pc_src, 0);
    chk("mid_rst_tgt",   bus.branch_target, 0);
    chk("mid_rst_rdata", bus.read_data_out, 0);
    idle();
    tick();
    rst_n = 1'b1;
    ex(32'h10, 32'h0, 32'h0, 5'd5, C_LW, 1'b0);
    tick();
    idle();
    tick();
    chk("mem_kept", bus.read_data_out, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
